// File: rtl/grn_ctrl_pkg.sv
// Shared types, default widths and the slow/fast compare rule for the
// gene-regulatory-network attractor controller.
package grn_ctrl_pkg;

  localparam int GRN_N_NODES   = 16;
  localparam int GRN_STEP_W    = 12;
  localparam int GRN_MAX_STEPS = 4094;

  // FSM state type kept as plain constants so older code can match on them
  typedef logic [2:0] grn_state_t;
  localparam grn_state_t ST_IDLE   = 3'd0;
  localparam grn_state_t ST_LOAD   = 3'd1;
  localparam grn_state_t ST_SETTLE = 3'd2;
  localparam grn_state_t ST_STEP   = 3'd3;
  localparam grn_state_t ST_CHECK  = 3'd4;
  localparam grn_state_t ST_REPORT = 3'd5;
  localparam grn_state_t ST_NEXT   = 3'd6;

  typedef enum logic [1:0] {
    CHK_STEP    = 2'd0,
    CHK_MATCH   = 2'd1,
    CHK_TIMEOUT = 2'd2
  } grn_check_e;

  // Odd step counts are never compared: the slow copy has just caught up trivially
  function automatic grn_check_e check_rule(input logic k_odd, input logic vec_eq,
                                            input logic at_limit);
    grn_check_e verdict;
    if (k_odd) begin
      verdict = CHK_STEP;
    end else if (vec_eq) begin
      verdict = CHK_MATCH;
    end else if (at_limit) begin
      verdict = CHK_TIMEOUT;
    end else begin
      verdict = CHK_STEP;
    end
    return verdict;
  endfunction

endpackage

// File: rtl/grn_init_seq.sv
// Walks the initial-state range: current state and number of states left,
// with a flag for the final one.
module grn_init_seq
  import grn_ctrl_pkg::*;
#(
  parameter int N_NODES = GRN_N_NODES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [N_NODES-1:0] first,
  input  logic [N_NODES-1:0] count,
  input  logic               advance,
  output logic [N_NODES-1:0] cur,
  output logic               last
);

  localparam logic [N_NODES-1:0] ONE = {{(N_NODES-1){1'b0}}, 1'b1};

  logic [N_NODES-1:0] cur_r;
  logic [N_NODES-1:0] remaining_r;

  // Range registers; cur wraps naturally at 2^N_NODES
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_r       <= {N_NODES{1'b0}};
      remaining_r <= {N_NODES{1'b0}};
    end else if (load) begin
      cur_r       <= first;
      remaining_r <= count;
    end else if (advance) begin
      cur_r       <= cur_r + ONE;
      remaining_r <= remaining_r - ONE;
    end
  end

  assign cur  = cur_r;
  assign last = (remaining_r == ONE);

endmodule

// File: rtl/grn_attractor_ctrl.sv
// Sequences load/step pulses over a range of initial states, detects the
// attractor with a Floyd slow/fast compare and streams one record per state.
module grn_attractor_ctrl
  import grn_ctrl_pkg::*;
#(
  parameter int N_NODES   = GRN_N_NODES,
  parameter int STEP_W    = GRN_STEP_W,
  parameter int MAX_STEPS = GRN_MAX_STEPS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_NODES-1:0] init_first,
  input  logic [N_NODES-1:0] init_count,
  input  logic [N_NODES-1:0] s0_vec,
  input  logic [N_NODES-1:0] s1_vec,
  output logic               reset_nos,
  output logic [N_NODES-1:0] init_state,
  output logic               start_s0,
  output logic               start_s1,
  output logic               busy,
  output logic               done,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [N_NODES-1:0] res_init,
  output logic [N_NODES-1:0] res_state,
  output logic [STEP_W-1:0]  res_steps,
  output logic               res_timeout
);

  localparam logic [STEP_W-1:0]  MAX_K    = MAX_STEPS[STEP_W-1:0];
  localparam logic [STEP_W-1:0]  K_ONE    = {{(STEP_W-1){1'b0}}, 1'b1};
  localparam logic [N_NODES-1:0] CNT_ZERO = {N_NODES{1'b0}};

  grn_state_t         state_r, state_nx_s;
  grn_check_e         verdict_s;
  logic [STEP_W-1:0]  k_r;
  logic [N_NODES-1:0] cur_s;
  logic               last_s, accept_s, empty_run_s, advance_s;
  logic               reset_nos_r, step_r, busy_r, done_r, res_valid_r, res_timeout_r;
  logic [N_NODES-1:0] res_state_r;
  logic [STEP_W-1:0]  res_steps_r;

  assign accept_s    = (state_r == ST_IDLE) && start && (init_count != CNT_ZERO);
  assign empty_run_s = (state_r == ST_IDLE) && start && (init_count == CNT_ZERO);
  assign advance_s   = (state_r == ST_NEXT);

  grn_init_seq #(.N_NODES(N_NODES)) u_init_seq (
    .clk     (clk),
    .rst     (rst),
    .load    (accept_s),
    .first   (init_first),
    .count   (init_count),
    .advance (advance_s),
    .cur     (cur_s),
    .last    (last_s)
  );

  // Next-state decode; CHECK sees node registers already updated by STEP
  always_comb begin
    state_nx_s = state_r;
    verdict_s  = check_rule(k_r[0], (s0_vec == s1_vec), (k_r == MAX_K));
    case (state_r)
      ST_IDLE:   if (accept_s) state_nx_s = ST_LOAD; else state_nx_s = ST_IDLE;
      ST_LOAD:   state_nx_s = ST_SETTLE;
      ST_SETTLE: state_nx_s = ST_STEP;
      ST_STEP:   state_nx_s = ST_CHECK;
      ST_CHECK:  if (verdict_s == CHK_STEP) state_nx_s = ST_STEP; else state_nx_s = ST_REPORT;
      ST_REPORT: if (res_ready) state_nx_s = ST_NEXT; else state_nx_s = ST_REPORT;
      ST_NEXT:   if (last_s) state_nx_s = ST_IDLE; else state_nx_s = ST_LOAD;
      default:   state_nx_s = ST_IDLE;
    endcase
  end

  // State, step counter, result capture and pulse outputs registered from next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      k_r           <= {STEP_W{1'b0}};
      reset_nos_r   <= 1'b0;
      step_r        <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      res_valid_r   <= 1'b0;
      res_timeout_r <= 1'b0;
      res_state_r   <= {N_NODES{1'b0}};
      res_steps_r   <= {STEP_W{1'b0}};
    end else begin
      state_r     <= state_nx_s;
      reset_nos_r <= (state_nx_s == ST_LOAD);
      step_r      <= (state_nx_s == ST_STEP);
      res_valid_r <= (state_nx_s == ST_REPORT);
      done_r      <= empty_run_s || ((state_nx_s == ST_NEXT) && last_s);
      if (accept_s) begin
        busy_r <= 1'b1;
      end else if (advance_s && last_s) begin
        busy_r <= 1'b0;
      end
      if (state_r == ST_LOAD) begin
        k_r <= {STEP_W{1'b0}};
      end else if (state_r == ST_STEP) begin
        k_r <= k_r + K_ONE;
      end
      if ((state_r == ST_CHECK) && (verdict_s != CHK_STEP)) begin
        res_state_r   <= s0_vec;
        res_steps_r   <= k_r;
        res_timeout_r <= (verdict_s == CHK_TIMEOUT);
      end
    end
  end

  assign reset_nos   = reset_nos_r;
  assign init_state  = cur_s;
  assign start_s0    = step_r;
  assign start_s1    = step_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign res_valid   = res_valid_r;
  assign res_init    = cur_s;
  assign res_state   = res_state_r;
  assign res_steps   = res_steps_r;
  assign res_timeout = res_timeout_r;

endmodule

// File: tb/tb_grn_attractor_ctrl.sv
// Bench: two controllers (long and short step limit) driving a modelled node
// array; records checked against an iterate-the-network reference.
module tb_grn_attractor_ctrl;

  localparam int N = 4;
  typedef struct packed {
    logic [3:0]  init;
    logic [3:0]  state;
    logic [11:0] steps;
    logic        to;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, res_ready;
  logic [1:0]   start;
  logic [N-1:0] init_first, init_count;
  logic [N-1:0] s0_vec [2];
  logic [N-1:0] s1_vec [2];
  logic [N-1:0] init_state [2];
  logic [N-1:0] res_init [2];
  logic [N-1:0] res_state [2];
  logic [1:0]   reset_nos, start_s0, start_s1, busy, done, res_valid, res_timeout, par;
  logic [11:0]  res_steps0;
  logic [2:0]   res_steps1;

  int   checks = 0;
  int   errors = 0;
  int   net_sel = 0;
  int   ready_mode = 0;
  int   done_cnt [2] = '{0, 0};
  logic [3:0] rnd_tab [16];
  rec_t expq [$];
  logic [1:0] hold_r = 2'b00;
  rec_t hold_rec [2];

  grn_attractor_ctrl #(.N_NODES(4), .STEP_W(12), .MAX_STEPS(4094)) u_big (
    .clk(clk), .rst(rst), .start(start[0]), .init_first(init_first), .init_count(init_count),
    .s0_vec(s0_vec[0]), .s1_vec(s1_vec[0]), .reset_nos(reset_nos[0]), .init_state(init_state[0]),
    .start_s0(start_s0[0]), .start_s1(start_s1[0]), .busy(busy[0]), .done(done[0]),
    .res_valid(res_valid[0]), .res_ready(res_ready), .res_init(res_init[0]),
    .res_state(res_state[0]), .res_steps(res_steps0), .res_timeout(res_timeout[0]));

  grn_attractor_ctrl #(.N_NODES(4), .STEP_W(3), .MAX_STEPS(6)) u_small (
    .clk(clk), .rst(rst), .start(start[1]), .init_first(init_first), .init_count(init_count),
    .s0_vec(s0_vec[1]), .s1_vec(s1_vec[1]), .reset_nos(reset_nos[1]), .init_state(init_state[1]),
    .start_s0(start_s0[1]), .start_s1(start_s1[1]), .busy(busy[1]), .done(done[1]),
    .res_valid(res_valid[1]), .res_ready(res_ready), .res_init(res_init[1]),
    .res_state(res_state[1]), .res_steps(res_steps1), .res_timeout(res_timeout[1]));

  function automatic logic [3:0] net_f(input int net, input logic [3:0] x);
    case (net)
      0:       return x;
      1:       return {x[2:0], x[3]};
      2:       return ~x;
      3:       return x + 4'd1;
      default: return rnd_tab[x];
    endcase
  endfunction

  function automatic logic [3:0] model_iter(input int net, input logic [3:0] x, input int n);
    logic [3:0] v = x;
    for (int j = 0; j < n; j++) v = net_f(net, v);
    return v;
  endfunction

  // Floyd reference: slow copy has taken k/2 steps when the fast one has taken k
  function automatic rec_t model_run(input int net, input logic [3:0] x, input int max);
    rec_t r;
    for (int k = 2; k <= max; k += 2) begin
      if (model_iter(net, x, k / 2) == model_iter(net, x, k)) begin
        r = '{init: x, state: model_iter(net, x, k / 2), steps: 12'(k), to: 1'b0};
        return r;
      end
    end
    r = '{init: x, state: model_iter(net, x, max / 2), steps: 12'(max), to: 1'b1};
    return r;
  endfunction

  // Node array: s1 steps on every pulse, s0 on the 1st, 3rd, 5th... after a load
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset_nos[i]) begin
        s0_vec[i] <= init_state[i];
        s1_vec[i] <= init_state[i];
        par[i]    <= 1'b0;
      end else begin
        if (start_s1[i]) s1_vec[i] <= net_f(net_sel, s1_vec[i]);
        if (start_s0[i]) begin
          par[i] <= ~par[i];
          if (!par[i]) s0_vec[i] <= net_f(net_sel, s0_vec[i]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input rec_t act, input rec_t exp);
    chk({tag, "_init"}, 32'(act.init), 32'(exp.init));
    chk({tag, "_state"}, 32'(act.state), 32'(exp.state));
    chk({tag, "_steps"}, 32'(act.steps), 32'(exp.steps));
    chk({tag, "_timeout"}, 32'(act.to), 32'(exp.to));
  endtask

  function automatic rec_t cur_rec(input int i);
    rec_t r;
    r.init  = res_init[i];
    r.state = res_state[i];
    r.steps = (i == 0) ? res_steps0 : {9'd0, res_steps1};
    r.to    = res_timeout[i];
    return r;
  endfunction

  function automatic logic [31:0] outs(input int i);
    logic [11:0] st = (i == 0) ? res_steps0 : {9'd0, res_steps1};
    return {1'b0, reset_nos[i], start_s0[i], start_s1[i], busy[i], done[i], res_valid[i],
            res_timeout[i], init_state[i], res_init[i], res_state[i], st};
  endfunction

  // Per-cycle compare against scoreboard and protocol rules
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        chk("s0_s1_same", 32'(start_s0[i]), 32'(start_s1[i]));
        chk("load_step_excl", 32'(reset_nos[i] & start_s0[i]), 32'd0);
        chk("pulse_needs_busy", 32'((reset_nos[i] | start_s0[i] | res_valid[i]) & ~busy[i]), 32'd0);
        if (res_valid[i]) chk("quiet_in_report", 32'(reset_nos[i] | start_s0[i]), 32'd0);
        if (hold_r[i]) begin
          chk("hold_valid", 32'(res_valid[i]), 32'd1);
          chk_rec("hold", cur_rec(i), hold_rec[i]);
        end
        if (res_valid[i] && res_ready) begin
          chk("record_expected", 32'(expq.size() != 0), 32'd1);
          if (expq.size() != 0) chk_rec("rec", cur_rec(i), expq.pop_front());
        end
        if (done[i]) begin
          chk("done_after_records", 32'(expq.size()), 32'd0);
          done_cnt[i] = done_cnt[i] + 1;
        end
        hold_r[i]   <= res_valid[i] && !res_ready;
        hold_rec[i] <= cur_rec(i);
      end else begin
        hold_r[i] <= 1'b0;
      end
    end
  end

  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) res_ready = 1'($urandom);
      else res_ready = (ready_mode == 0);
    end
  end

  task automatic go(input int inst, input logic [3:0] first, input logic [3:0] cnt);
    @(posedge clk); #1;
    init_first  = first;
    init_count  = cnt;
    start[inst] = 1'b1;
    @(posedge clk); #1;
    start = 2'b00;
  endtask

  task automatic push(input logic [3:0] ini, input logic [3:0] st, input int k, input logic to);
    expq.push_back('{init: ini, state: st, steps: 12'(k), to: to});
  endtask

  task automatic wait_done(input int inst, input int budget);
    int base = done_cnt[inst];
    for (int c = 0; c < budget && done_cnt[inst] == base; c++) @(posedge clk);
    chk("done_seen", 32'(done_cnt[inst] - base), 32'd1);
    @(negedge clk);
    chk("busy_low_after_done", 32'(busy[inst]), 32'd0);
    repeat (3) @(negedge clk);
    chk("single_done", 32'(done_cnt[inst] - base), 32'd1);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    expq.delete();
  endtask

  initial begin
    int   base;
    logic seen;
    rec_t r;
    rst = 1'b1; start = 2'b00; init_first = 4'd0; init_count = 4'd0;
    for (int j = 0; j < 16; j++) rnd_tab[j] = 4'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs_big", outs(0), 32'd0);
    chk("reset_outs_small", outs(1), 32'd0);
    rst = 1'b0;

    r = model_run(1, 4'b0001, 4094); chk("pin_rotl_steps", 32'(r.steps), 32'd8);
    r = model_run(2, 4'b0000, 4094); chk("pin_not_steps", 32'(r.steps), 32'd4);
    r = model_run(3, 4'b0000, 6);
    chk("pin_cnt_to", 32'(r.to), 32'd1);
    chk("pin_cnt_state", 32'(r.state), 32'd3);

    net_sel = 0; push(4'b0101, 4'b0101, 2, 1'b0); go(0, 4'b0101, 4'd1); wait_done(0, 200);
    net_sel = 1; push(4'b0001, 4'b0001, 8, 1'b0); go(0, 4'b0001, 4'd1); wait_done(0, 200);
    net_sel = 2; push(4'b0000, 4'b0000, 4, 1'b0); go(0, 4'b0000, 4'd1); wait_done(0, 200);
    net_sel = 1;
    push(4'b1110, 4'b1110, 8, 1'b0); push(4'b1111, 4'b1111, 2, 1'b0); push(4'b0000, 4'b0000, 2, 1'b0);
    go(0, 4'b1110, 4'd3); wait_done(0, 400);
    net_sel = 3; push(4'b0000, 4'b0011, 6, 1'b1); go(1, 4'b0000, 4'd1); wait_done(1, 200);

    // back-pressure: record held 20 cycles, then NEXT followed by LOAD
    net_sel = 0; ready_mode = 2;
    push(4'd9, 4'd9, 2, 1'b0); push(4'd10, 4'd10, 2, 1'b0);
    go(0, 4'd9, 4'd2);
    for (int c = 0; c < 200 && !res_valid[0]; c++) @(negedge clk);
    chk("valid_seen", 32'(res_valid[0]), 32'd1);
    repeat (20) @(negedge clk);
    ready_mode = 0;
    @(negedge clk); chk("xfer", 32'(res_valid[0] & res_ready), 32'd1);
    @(negedge clk); chk("next_no_load", 32'(reset_nos[0]), 32'd0);
    @(negedge clk); chk("load_after_next", 32'(reset_nos[0]), 32'd1);
    wait_done(0, 200);

    base = done_cnt[0]; seen = 1'b0;
    go(0, 4'd3, 4'd0);
    repeat (4) begin @(negedge clk); seen = seen | busy[0] | reset_nos[0]; end
    chk("empty_run_done", 32'(done_cnt[0] - base), 32'd1);
    chk("empty_run_quiet", 32'(seen), 32'd0);

    // reset in the middle of stepping
    net_sel = 1; push(4'd1, 4'd1, 8, 1'b0);
    go(0, 4'd1, 4'd1);
    for (int c = 0; c < 50 && !start_s0[0]; c++) @(negedge clk);
    chk("step_seen", 32'(start_s0[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrun_rst_outs", outs(0), 32'd0);
    rst = 1'b0; expq.delete(); base = done_cnt[0];
    repeat (20) @(negedge clk);
    chk("midrun_rst_no_done", 32'(done_cnt[0] - base), 32'd0);

    // start while busy has no effect on the running range
    push(4'd1, 4'd1, 8, 1'b0); push(4'd2, 4'd2, 8, 1'b0);
    go(0, 4'd1, 4'd2);
    repeat (5) @(posedge clk);
    go(0, 4'hC, 4'd3);
    wait_done(0, 400);

    ready_mode = 1;
    for (int run = 0; run < 8; run++) begin
      int inst = int'($urandom_range(1, 0));
      logic [3:0] first = 4'($urandom);
      logic [3:0] cnt = 4'($urandom_range(4, 1));
      net_sel = int'($urandom_range(4, 0));
      for (int j = 0; j < int'(cnt); j++)
        expq.push_back(model_run(net_sel, first + 4'(j), (inst == 0) ? 4094 : 6));
      go(inst, first, cnt);
      wait_done(inst, 4000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
